// File: rtl/wide_cmp_seq_if.sv
// rtl/wide_cmp_seq_if.sv - request/result and compare-slice signal bundle for wide_cmp_seq
// Purpose: groups the controller handshake (START/A/B -> BUSY/DONE/L/E/G/ERR)
//          and the shared 4-bit slice drive/return (SA/SB/SxIN -> SL/SE/SG).
// Ports (modport slave = sequencer side):
//   in : START, A[WIDTH], B[WIDTH], SL, SE, SG
//   out: BUSY, DONE, L, E, G, ERR, SA[4], SB[4], SLIN, SEIN, SGIN
interface wide_cmp_seq_if #(
  parameter int WIDTH = 16
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic             L;
  logic             E;
  logic             G;
  logic             ERR;
  logic [3:0]       SA;
  logic [3:0]       SB;
  logic             SLIN;
  logic             SEIN;
  logic             SGIN;
  logic             SL;
  logic             SE;
  logic             SG;

  modport slave (
    input  START, A, B, SL, SE, SG,
    output BUSY, DONE, L, E, G, ERR, SA, SB, SLIN, SEIN, SGIN
  );

  modport master (
    output START, A, B, SL, SE, SG,
    input  BUSY, DONE, L, E, G, ERR, SA, SB, SLIN, SEIN, SGIN
  );
endinterface

// File: rtl/wide_cmp_seq.sv
// rtl/wide_cmp_seq.sv - MSB-first wide unsigned compare over one shared 4-bit cascadable slice
// Purpose: latches A/B on an accepted START, walks the nibbles MSB-first through
//          the external combinational slice, chains the slice L/E/G back into
//          its cascade inputs, and reports a held L/E/G/ERR with a DONE pulse.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - wide_cmp_seq_if.slave (handshake, operands, results, slice drive/return)
module wide_cmp_seq #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  wide_cmp_seq_if.slave bus
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  // Cascade value that makes a slice behave as the most significant one.
  localparam logic [2:0] CAS_EQ = 3'b010;

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [2:0]       cas_q, cas_d;
  logic             l_q, l_d;
  logic             e_q, e_d;
  logic             g_q, g_d;
  logic             err_q, err_d;

  logic             run;
  logic [2:0]       slice_out;
  logic             one_hot;

  assign run       = (state_q == S_RUN);
  assign slice_out = {bus.SL, bus.SE, bus.SG};
  assign one_hot   = (slice_out == 3'b100) || (slice_out == 3'b010) ||
                     (slice_out == 3'b001);

  // Slice is parked at "equal, zero nibbles" whenever it is not in use.
  assign bus.SA   = run ? opa_q[{idx_q, 2'b00} +: 4] : 4'h0;
  assign bus.SB   = run ? opb_q[{idx_q, 2'b00} +: 4] : 4'h0;
  assign bus.SLIN = run ? cas_q[2] : CAS_EQ[2];
  assign bus.SEIN = run ? cas_q[1] : CAS_EQ[1];
  assign bus.SGIN = run ? cas_q[0] : CAS_EQ[0];

  assign bus.BUSY = run;
  assign bus.DONE = (state_q == S_FIN);
  assign bus.L    = l_q;
  assign bus.E    = e_q;
  assign bus.G    = g_q;
  assign bus.ERR  = err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cas_d   = cas_q;
    l_d     = l_q;
    e_d     = e_q;
    g_d     = g_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        // FIN also accepts START so back-to-back requests lose no cycle.
        if (bus.START) begin
          opa_d   = bus.A;
          opb_d   = bus.B;
          idx_d   = IDX_LAST;
          cas_d   = CAS_EQ;
          l_d     = 1'b0;
          e_d     = 1'b0;
          g_d     = 1'b0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        cas_d = slice_out;
        if (!one_hot) begin
          err_d   = 1'b1;
          l_d     = 1'b0;
          e_d     = 1'b0;
          g_d     = 1'b0;
          state_d = S_FIN;
        end else if ((idx_q == '0) || (EARLY_EXIT && !bus.SE)) begin
          // Once a nibble differs the cascade pins the answer, so lower
          // nibbles cannot change it; stopping early is purely a latency win.
          l_d     = bus.SL;
          e_d     = bus.SE;
          g_d     = bus.SG;
          state_d = S_FIN;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_LAST;
      opa_q   <= '0;
      opb_q   <= '0;
      cas_q   <= CAS_EQ;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cas_q   <= cas_d;
      l_q     <= l_d;
      e_q     <= e_d;
      g_q     <= g_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wide_cmp_seq.sv
// tb/tb_wide_cmp_seq.sv - self-checking bench for wide_cmp_seq (early-exit and full-walk builds)
module tb_wide_cmp_seq;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       l;
    logic       e;
    logic       g;
    logic       err;
    logic [3:0] sa;
    logic [3:0] sb;
    logic       slin;
    logic       sein;
    logic       sgin;
  } obs_t;

  typedef struct {
    logic [3:0] res;  // {L,E,G,ERR}
    int         lat;  // cycles from accept edge to DONE
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start1, start0;
  logic [15:0] a_s, b_s;
  bit          force_err;

  int n_cmp;
  int n_bad;

  exp_t sb1[$];
  exp_t sb0[$];

  wide_cmp_seq_if #(.WIDTH(16)) bus1 ();
  wide_cmp_seq_if #(.WIDTH(16)) bus0 ();

  wide_cmp_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut1 (
    .CLK (clk),
    .RST (rst),
    .bus (bus1.slave)
  );

  wide_cmp_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (
    .CLK (clk),
    .RST (rst),
    .bus (bus0.slave)
  );

  // Behavioural slice: an unequal cascade from the higher nibble dominates.
  function automatic logic [2:0] slice(input logic [3:0] sa, input logic [3:0] sb,
                                       input logic l, input logic e, input logic g,
                                       input bit ferr);
    if (ferr) return 3'b101;
    if (!e) return {l, 1'b0, g};
    if (sa < sb) return 3'b100;
    if (sa > sb) return 3'b001;
    return 3'b010;
  endfunction

  assign bus1.START = start1;
  assign bus1.A     = a_s;
  assign bus1.B     = b_s;
  assign {bus1.SL, bus1.SE, bus1.SG} =
    slice(bus1.SA, bus1.SB, bus1.SLIN, bus1.SEIN, bus1.SGIN, force_err);

  assign bus0.START = start0;
  assign bus0.A     = a_s;
  assign bus0.B     = b_s;
  assign {bus0.SL, bus0.SE, bus0.SG} =
    slice(bus0.SA, bus0.SB, bus0.SLIN, bus0.SEIN, bus0.SGIN, 1'b0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t obs(input bit sel);
    obs_t o;
    if (sel) o = {bus1.BUSY, bus1.DONE, bus1.L, bus1.E, bus1.G, bus1.ERR,
                  bus1.SA, bus1.SB, bus1.SLIN, bus1.SEIN, bus1.SGIN};
    else     o = {bus0.BUSY, bus0.DONE, bus0.L, bus0.E, bus0.G, bus0.ERR,
                  bus0.SA, bus0.SB, bus0.SLIN, bus0.SEIN, bus0.SGIN};
    return o;
  endfunction

  function automatic logic [3:0] ref_res(input logic [15:0] a, input logic [15:0] b);
    return {a < b, a == b, a > b, 1'b0};
  endfunction

  function automatic int ee_lat(input logic [15:0] a, input logic [15:0] b);
    for (int i = 3; i >= 0; i--)
      if (a[4*i +: 4] !== b[4*i +: 4]) return (4 - i) + 1;
    return 5;
  endfunction

  // Drives a one-cycle START; returns just after the accepting edge.
  task automatic start_op(input bit sel, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    a_s = a;
    b_s = b;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start0 = 1'b0;
  endtask

  // Counts negedges until DONE (cyc = -1 if the budget runs out).
  task automatic wait_done(input bit sel, output int cyc, output int busy_n, output obs_t od);
    obs_t o;
    cyc    = -1;
    busy_n = 0;
    od     = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      o = obs(sel);
      if (o.busy) busy_n++;
      if (o.done) begin
        cyc = i;
        od  = o;
        break;
      end
    end
  endtask

  task automatic test_reset;
    obs_t o;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = obs(s[0]);
      n_cmp++;
      if ({o.busy, o.done, o.l, o.e, o.g, o.err} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_outputs dut%0d got %b want 000000", s,
                 {o.busy, o.done, o.l, o.e, o.g, o.err});
      end
      n_cmp++;
      if ({o.sa, o.sb, o.slin, o.sein, o.sgin} !== {8'h00, 3'b010}) begin
        n_bad++;
        $display("FAIL reset_slice_drive dut%0d got %h want %h", s,
                 {o.sa, o.sb, o.slin, o.sein, o.sgin}, {8'h00, 3'b010});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_equal;
    exp_t e;
    obs_t o;
    int cyc, bn;
    sb1.push_back('{res: ref_res(16'h1234, 16'h1234), lat: ee_lat(16'h1234, 16'h1234)});
    start_op(1'b1, 16'h1234, 16'h1234);
    wait_done(1'b1, cyc, bn, o);
    e = sb1.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin
      n_bad++; $display("FAIL equal_latency got %0d want %0d", cyc, e.lat);
    end
    n_cmp++;
    if (bn !== 4) begin
      n_bad++; $display("FAIL equal_busy_cycles got %0d want 4", bn);
    end
    n_cmp++;
    if ({o.l, o.e, o.g, o.err} !== e.res) begin
      n_bad++; $display("FAIL equal_result got %b want %b", {o.l, o.e, o.g, o.err}, e.res);
    end
  endtask

  task automatic test_early_exit;
    exp_t e;
    obs_t o;
    int cyc, bn;
    sb1.push_back('{res: 4'b0010, lat: 2});
    start_op(1'b1, 16'h8000, 16'h7FFF);
    @(negedge clk);
    o = obs(1'b1);
    n_cmp++;
    if ({o.busy, o.sa, o.sb} !== {1'b1, 4'h8, 4'h7}) begin
      n_bad++; $display("FAIL early_first_nibble got %h want %h", {o.busy, o.sa, o.sb}, {1'b1, 4'h8, 4'h7});
    end
    wait_done(1'b1, cyc, bn, o);
    e = sb1.pop_front();
    n_cmp++;
    if (cyc + 1 !== e.lat) begin
      n_bad++; $display("FAIL early_latency got %0d want %0d", cyc + 1, e.lat);
    end
    n_cmp++;
    if ({o.l, o.e, o.g, o.err} !== e.res) begin
      n_bad++; $display("FAIL early_result got %b want %b", {o.l, o.e, o.g, o.err}, e.res);
    end
  endtask

  task automatic test_partial;
    exp_t e;
    obs_t o;
    int cyc, bn;
    sb1.push_back('{res: 4'b1000, lat: 3});
    start_op(1'b1, 16'h12F0, 16'h1300);
    wait_done(1'b1, cyc, bn, o);
    e = sb1.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin
      n_bad++; $display("FAIL partial_latency got %0d want %0d", cyc, e.lat);
    end
    n_cmp++;
    if ({o.l, o.e, o.g, o.err} !== e.res) begin
      n_bad++; $display("FAIL partial_result got %b want %b", {o.l, o.e, o.g, o.err}, e.res);
    end
  endtask

  task automatic test_no_early_exit;
    exp_t e;
    obs_t o;
    int cyc, bn;
    logic [3:0] want;
    sb0.push_back('{res: 4'b0010, lat: 5});
    start_op(1'b0, 16'h8000, 16'h7FFF);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      o = obs(1'b0);
      want = (i == 1) ? 4'b1010 : 4'b1001;  // {BUSY,SLIN,SEIN,SGIN}
      n_cmp++;
      if ({o.busy, o.slin, o.sein, o.sgin} !== want) begin
        n_bad++; $display("FAIL full_cascade_n%0d got %b want %b", i, {o.busy, o.slin, o.sein, o.sgin}, want);
      end
    end
    wait_done(1'b0, cyc, bn, o);
    e = sb0.pop_front();
    n_cmp++;
    if (cyc + 4 !== e.lat) begin
      n_bad++; $display("FAIL full_latency got %0d want %0d", cyc + 4, e.lat);
    end
    n_cmp++;
    if ({o.l, o.e, o.g, o.err} !== e.res) begin
      n_bad++; $display("FAIL full_result got %b want %b", {o.l, o.e, o.g, o.err}, e.res);
    end
    @(negedge clk);
    o = obs(1'b0);
    n_cmp++;
    if ({o.done, o.l, o.e, o.g} !== 4'b0001) begin
      n_bad++; $display("FAIL full_result_held got %b want 0001", {o.done, o.l, o.e, o.g});
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    obs_t o;
    int cyc, bn;
    sb1.push_back('{res: 4'b0100, lat: 5});
    @(negedge clk);
    a_s = 16'h1234;
    b_s = 16'h1234;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    // START stays high and operands move; neither may disturb the run.
    a_s = 16'h0000;
    b_s = 16'hFFFF;
    wait_done(1'b1, cyc, bn, o);
    e = sb1.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin
      n_bad++; $display("FAIL held_start_latency got %0d want %0d", cyc, e.lat);
    end
    n_cmp++;
    if ({o.l, o.e, o.g, o.err} !== e.res) begin
      n_bad++; $display("FAIL held_start_result got %b want %b", {o.l, o.e, o.g, o.err}, e.res);
    end
    a_s = 16'hFFFF;
    b_s = 16'hFFFF;
    sb1.push_back('{res: 4'b0100, lat: 5});
    @(posedge clk);
    #1;
    start1 = 1'b0;
    @(negedge clk);
    o = obs(1'b1);
    n_cmp++;
    if ({o.busy, o.done} !== 2'b10) begin
      n_bad++; $display("FAIL b2b_busy_next got %b want 10", {o.busy, o.done});
    end
    wait_done(1'b1, cyc, bn, o);
    e = sb1.pop_front();
    n_cmp++;
    if (cyc + 1 !== e.lat) begin
      n_bad++; $display("FAIL b2b_latency got %0d want %0d", cyc + 1, e.lat);
    end
    n_cmp++;
    if ({o.l, o.e, o.g, o.err} !== e.res) begin
      n_bad++; $display("FAIL b2b_result got %b want %b", {o.l, o.e, o.g, o.err}, e.res);
    end
  endtask

  task automatic test_error;
    exp_t e;
    obs_t o;
    int cyc, bn;
    force_err = 1'b1;
    sb1.push_back('{res: 4'b0001, lat: 2});
    start_op(1'b1, 16'h5555, 16'h5555);
    wait_done(1'b1, cyc, bn, o);
    force_err = 1'b0;
    e = sb1.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin
      n_bad++; $display("FAIL error_latency got %0d want %0d", cyc, e.lat);
    end
    n_cmp++;
    if ({o.l, o.e, o.g, o.err} !== e.res) begin
      n_bad++; $display("FAIL error_result got %b want %b", {o.l, o.e, o.g, o.err}, e.res);
    end
    @(negedge clk);
    o = obs(1'b1);
    n_cmp++;
    if ({o.done, o.err} !== 2'b01) begin
      n_bad++; $display("FAIL error_held got %b want 01", {o.done, o.err});
    end
  endtask

  task automatic test_reset_mid_run;
    obs_t o;
    int dones;
    start_op(1'b0, 16'h1234, 16'h1235);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    o = obs(1'b0);
    n_cmp++;
    if ({o.busy, o.done, o.sein, o.l, o.e, o.g, o.err} !== 7'b0010000) begin
      n_bad++; $display("FAIL midrun_reset got %b want 0010000",
                        {o.busy, o.done, o.sein, o.l, o.e, o.g, o.err});
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (obs(1'b0).done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++; $display("FAIL midrun_no_done got %0d want 0", dones);
    end
  endtask

  task automatic test_random;
    exp_t e;
    obs_t o;
    int cyc, bn;
    logic [15:0] a, b;
    for (int it = 0; it < 8; it++) begin
      a = 16'($urandom);
      case (it % 3)
        0:       b = 16'($urandom);
        1:       b = a;
        default: b = a ^ (16'h1 << $urandom_range(0, 15));
      endcase
      for (int s = 0; s < 2; s++) begin
        if (s == 1) sb1.push_back('{res: ref_res(a, b), lat: ee_lat(a, b)});
        else        sb0.push_back('{res: ref_res(a, b), lat: 5});
        start_op(s[0], a, b);
        wait_done(s[0], cyc, bn, o);
        e = (s == 1) ? sb1.pop_front() : sb0.pop_front();
        n_cmp++;
        if (cyc !== e.lat || {o.l, o.e, o.g, o.err} !== e.res) begin
          n_bad++;
          $display("FAIL random_dut%0d a=%h b=%h got lat %0d res %b want lat %0d res %b",
                   s, a, b, cyc, {o.l, o.e, o.g, o.err}, e.lat, e.res);
        end
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    start1    = 1'b0;
    start0    = 1'b0;
    a_s       = '0;
    b_s       = '0;
    force_err = 1'b0;
    test_reset();
    test_equal();
    test_early_exit();
    test_partial();
    test_no_early_exit();
    test_back_to_back();
    test_error();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
